// File: rtl/pipe_stage_if.sv
// pipe_stage_if
//   Upstream/downstream handshake and payload bundle for pipe_stage_reg.
//   Parameters: DATA_W (alu/rd2/pc_branch width), REG_W (write_reg width),
//               CTRL_W (ctrl width).
//   master : the side that drives in_* and out_ready (producer + consumer).
//   slave  : the pipeline stage itself.
interface pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_rd2;
  logic [DATA_W-1:0] in_pc_branch;
  logic [REG_W-1:0]  in_write_reg;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_zero;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_rd2;
  logic [DATA_W-1:0] out_pc_branch;
  logic [REG_W-1:0]  out_write_reg;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_zero;

  modport master (
    output in_valid, in_alu, in_rd2, in_pc_branch, in_write_reg, in_ctrl, in_zero,
    input  in_ready,
    input  out_valid, out_alu, out_rd2, out_pc_branch, out_write_reg, out_ctrl, out_zero,
    output out_ready
  );

  modport slave (
    input  in_valid, in_alu, in_rd2, in_pc_branch, in_write_reg, in_ctrl, in_zero,
    output in_ready,
    output out_valid, out_alu, out_rd2, out_pc_branch, out_write_reg, out_ctrl, out_zero,
    input  out_ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Valid/ready pipeline register between execute and memory stages.
//   Freezes while the cache misses (hit low), discards held entries on
//   flush, and counts miss cycles in a saturating stall counter.
//
//   Ports:
//     clk        single clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        pipe_stage_if.slave: in_valid/in_ready + in_* payload,
//                out_valid/out_ready + out_* payload
//     hit        cache hit; low freezes the stage
//     flush      discard all held entries at the next edge
//     stall_cnt  saturating count of cycles with hit low
//
//   Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry so
//   that in_ready depends only on registered state and not on out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_if.slave      bus,
  input  logic             hit,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PAY_W = 3 * DATA_W + REG_W + CTRL_W + 1;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             run_q;
  logic             in_ready;
  logic             in_fire;
  logic             out_fire;

  assign in_pay = {bus.in_alu, bus.in_rd2, bus.in_pc_branch,
                   bus.in_write_reg, bus.in_ctrl, bus.in_zero};

  assign {bus.out_alu, bus.out_rd2, bus.out_pc_branch,
          bus.out_write_reg, bus.out_ctrl, bus.out_zero} = head_q;
  assign bus.out_valid = head_valid_q;
  assign bus.in_ready  = in_ready;

  // run_q keeps in_ready low during reset and until the first edge after
  // release, since the empty head alone would otherwise advertise ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Flush also blocks retirement so that no transfer happens that cycle.
  assign out_fire = head_valid_q && bus.out_ready && hit && !flush;
  assign in_fire  = bus.in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;

  // Registered-only ready: the skid entry absorbs the one payload that may
  // arrive while the head is blocked by out_ready.
  assign in_ready = run_q && !skid_valid_q && hit && !flush;

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no in_fire here.
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        head_d = in_pay;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!head_valid_q) begin
        head_d       = in_pay;
        head_valid_d = 1'b1;
      end else begin
        skid_d       = in_pay;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = run_q && hit && !flush && (!head_valid_q || bus.out_ready);

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
    end else if (in_fire) begin
      // Covers simultaneous retire + accept: head is replaced, no bubble.
      head_d       = in_pay;
      head_valid_d = 1'b1;
    end else if (out_fire) begin
      head_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Miss-cycle counter; saturates and is deliberately not cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!hit && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the ALU result, store-data and branch-target fields.
REQ-002 The block SHALL have parameter REG_W, default 5, giving the width of the destination-register field.
REQ-003 The block SHALL have parameter CTRL_W, default 5, giving the width of the control-signal field.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the stage accepts the payload this cycle.
REQ-009 The block SHALL have payload inputs in_alu [DATA_W], in_rd2 [DATA_W], in_pc_branch [DATA_W], in_write_reg [REG_W], in_ctrl [CTRL_W] and in_zero [1].
REQ-010 The block SHALL have port hit, input, 1 bit: cache hit; low means memory miss and the stage is frozen.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-012 The block SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-014 The block SHALL have payload outputs out_alu, out_rd2, out_pc_branch, out_write_reg, out_ctrl and out_zero, with widths matching the inputs.
REQ-015 The block SHALL have port stall_cnt, output, CNT_W bits: number of cycles with hit low.

Function
REQ-016 The block SHALL define in_fire = in_valid && in_ready and out_fire = out_valid && out_ready && hit.
REQ-017 The block SHALL accept no payload and retire no payload while hit is low; held contents are unchanged (freeze).
REQ-018 While flush is high, the block SHALL force in_ready to 0, clear every held valid bit at the next edge, and perform no transfer; flush overrides hit.
REQ-019 The block SHALL drive out_* payload from the head entry; payload is undefined when out_valid is 0.
REQ-020 When out_fire and in_fire occur in the same cycle, the block SHALL replace the head with the incoming payload with no bubble.
REQ-021 The latency from in_fire to out_valid SHALL be 1 cycle.
REQ-022 The block SHALL preserve payload order; no entry is dropped or duplicated except by flush.
REQ-023 The block SHALL increment stall_cnt on every cycle with hit low, saturating at all-ones; flush does not clear it.

Reset
REQ-024 On assertion of rst_n low, the block SHALL immediately clear all valid bits and drive out_valid to 0, stall_cnt to 0 and all out_* payload to 0.
REQ-025 While rst_n is low, the block SHALL hold in_ready at 0; on the first edge after release, in_ready follows REQ-026 or REQ-027.
REQ-026 In the single-entry build, in_ready SHALL be hit && !flush && (!out_valid || out_ready), a combinational path from out_ready.

Configuration
REQ-027 With PIPE_STAGE_SKID_EN defined, the block SHALL add a second (skid) entry: in_ready = !skid_valid && hit && !flush, driven from registered state only; an in_fire while the head is held and out_fire is absent SHALL load the skid entry; an out_fire with the skid entry valid SHALL move the skid entry to the head.
REQ-028 With PIPE_STAGE_SKID_EN undefined, the block SHALL contain no skid storage and SHALL behave per REQ-026.

Verification
REQ-029 After reset, a single payload in_alu=0x0000_1234 with hit=1 and out_ready=1 SHALL produce out_valid=1 and out_alu=0x0000_1234 one cycle later, then out_valid=0.
REQ-030 A continuous stream of in_alu=1,2,3,4 with out_ready=1 SHALL appear as 1,2,3,4 on consecutive cycles with no bubbles.
REQ-031 Holding hit=0 for 3 cycles with a valid head of 0xA SHALL keep out_alu=0xA and in_ready=0, then stall_cnt=3, and a normal transfer SHALL resume when hit returns to 1.
REQ-032 Asserting flush for 1 cycle with in_valid=1 SHALL give out_valid=0 on the next cycle, and the flushed payload SHALL never appear.
REQ-033 With SKID_EN, out_ready=0 while payloads 5 and 6 are pushed SHALL make in_ready fall after 6; releasing out_ready SHALL output 5 then 6.
REQ-034 Asserting rst_n low mid-stream with a held payload SHALL clear out_valid and stall_cnt asynchronously, before the next clock edge.
